// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Arbitrates the single scoreboard writeback port among the functional
//   units (scalar ALU, scalar memory, matrix load/store, GEMM). One request is
//   granted per cycle, round-robin, and a requester that has waited MAX_WAIT
//   cycles is promoted ahead of the round-robin order. The winner is captured
//   in a registered output slot. Speculative results are squashed on
//   branch_miss, both at the requesters and in the held slot.
//
// Ports
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   fu_wb_valid      per-FU writeback request
//   fu_wb_reg        per-FU destination register, FU i at [i*REG_W +: REG_W]
//   fu_wb_data       per-FU result, FU i at [i*DATA_W +: DATA_W]
//   fu_wb_spec       per-FU "produced under an unresolved branch" flag
//   fu_wb_ready      per-FU acknowledge (combinational)
//   branch_miss      mispredict: drop every speculative result
//   branch_resolved  branch correct: held result becomes non-speculative
//   wb_ready         consumer accepts wb_* this cycle
//   wb_valid/wb_reg/wb_data/wb_fu  registered output slot
module wb_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_FU-1:0]         fu_wb_valid,
  input  logic [NUM_FU*REG_W-1:0]   fu_wb_reg,
  input  logic [NUM_FU*DATA_W-1:0]  fu_wb_data,
  input  logic [NUM_FU-1:0]         fu_wb_spec,
  output logic [NUM_FU-1:0]         fu_wb_ready,
  input  logic                      branch_miss,
  input  logic                      branch_resolved,
  input  logic                      wb_ready,
  output logic                      wb_valid,
  output logic [REG_W-1:0]          wb_reg,
  output logic [DATA_W-1:0]         wb_data,
  output logic [$clog2(NUM_FU)-1:0] wb_fu
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [FU_W-1:0]  LAST_FU = FU_W'(NUM_FU - 1);

  logic              wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]  wb_reg_q,   wb_reg_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic [FU_W-1:0]   wb_fu_q,    wb_fu_d;
  logic              out_spec_q, out_spec_d;
  logic [FU_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]  wait_cnt_q [NUM_FU];
  logic [CNT_W-1:0]  wait_cnt_d [NUM_FU];

  logic              load;
  logic              starved_hit, rr_hit, grant_valid;
  logic [FU_W-1:0]   starved_idx, rr_idx, grant_idx, idx;

  assign load = !wb_valid_q || wb_ready;

  // Grant selection: starved requesters (lowest index first) beat round-robin.
  always_comb begin
    starved_hit = 1'b0;
    starved_idx = '0;
    rr_hit      = 1'b0;
    rr_idx      = '0;
    idx         = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (!starved_hit && fu_wb_valid[i] && wait_cnt_q[i] == MAX_CNT) begin
        starved_hit = 1'b1;
        starved_idx = FU_W'(i);
      end
    end
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = FU_W'((32'(rr_ptr_q) + k) % NUM_FU);
      if (!rr_hit && fu_wb_valid[idx]) begin
        rr_hit = 1'b1;
        rr_idx = idx;
      end
    end
    grant_valid = load && !branch_miss && rr_hit;
    grant_idx   = starved_hit ? starved_idx : rr_idx;
  end

  // Acknowledge: on a mispredict every speculative requester is acked so its
  // result is consumed and dropped; otherwise only the winner is acked.
  always_comb begin
    fu_wb_ready = '0;
    if (nRST) begin
      if (branch_miss) begin
        fu_wb_ready = fu_wb_valid & fu_wb_spec;
      end else if (grant_valid) begin
        fu_wb_ready[grant_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    wb_fu_d    = wb_fu_q;
    out_spec_d = out_spec_q;
    rr_ptr_d   = rr_ptr_q;

    if (branch_miss) begin
      // A speculative held entry is killed even when stalled; a
      // non-speculative one leaves normally, with nothing replacing it.
      if (out_spec_q || load) begin
        wb_valid_d = 1'b0;
        out_spec_d = 1'b0;
      end
    end else if (load) begin
      if (grant_valid) begin
        wb_valid_d = 1'b1;
        wb_reg_d   = fu_wb_reg[grant_idx*REG_W +: REG_W];
        wb_data_d  = fu_wb_data[grant_idx*DATA_W +: DATA_W];
        wb_fu_d    = grant_idx;
        out_spec_d = fu_wb_spec[grant_idx];
        rr_ptr_d   = (grant_idx == LAST_FU) ? '0 : grant_idx + 1'b1;
      end else begin
        wb_valid_d = 1'b0;
        out_spec_d = 1'b0;
      end
    end else if (branch_resolved) begin
      out_spec_d = 1'b0;
    end

    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (!fu_wb_valid[i] || fu_wb_ready[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != MAX_CNT) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_fu_q    <= '0;
      out_spec_q <= 1'b0;
      rr_ptr_q   <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_fu_q    <= wb_fu_d;
      out_spec_q <= out_spec_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;
  assign wb_fu    = wb_fu_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Directed bench for wb_arbiter (NUM_FU=4, MAX_WAIT=2). Expected writebacks
//   are queued as requests are granted and compared when the consumer accepts
//   them; handshakes and held state are checked at each step.
module tb_wb_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  fu_wb_valid = '0;
  logic [19:0] fu_wb_reg = '0;
  logic [127:0] fu_wb_data = '0;
  logic [3:0]  fu_wb_spec = '0;
  logic [3:0]  fu_wb_ready;
  logic        branch_miss = 1'b0;
  logic        branch_resolved = 1'b0;
  logic        wb_ready = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  wb_fu;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [1:0]  f;
  } exp_t;
  exp_t sb[$];

  wb_arbiter #(.NUM_FU(4), .DATA_W(32), .REG_W(5), .MAX_WAIT(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .fu_wb_valid(fu_wb_valid), .fu_wb_reg(fu_wb_reg), .fu_wb_data(fu_wb_data),
    .fu_wb_spec(fu_wb_spec), .fu_wb_ready(fu_wb_ready),
    .branch_miss(branch_miss), .branch_resolved(branch_resolved),
    .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_data(wb_data), .wb_fu(wb_fu)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [4:0] r,
                        input logic [31:0] d, input logic s);
    fu_wb_valid[i]        = v;
    fu_wb_reg[i*5 +: 5]   = r;
    fu_wb_data[i*32 +: 32] = d;
    fu_wb_spec[i]         = s;
  endtask

  task automatic push_exp(input logic [4:0] r, input logic [31:0] d, input logic [1:0] f);
    exp_t e;
    e.r = r;
    e.d = d;
    e.f = f;
    sb.push_back(e);
  endtask

  // Consumer side: every accepted writeback must match the next expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && wb_valid && wb_ready) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed reg=%0d data=%0h fu=%0d expected no writeback",
               wb_reg, wb_data, wb_fu);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_reg", 64'(wb_reg), 64'(e.r));
        chk("sb_data", 64'(wb_data), 64'(e.d));
        chk("sb_fu", 64'(wb_fu), 64'(e.f));
      end
    end
  end

  initial begin
    // Reset with all FUs requesting: nothing may be acked while in reset.
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i), 1'b0);
    tick();
    tick();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_reg", 64'(wb_reg), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_fu", 64'(wb_fu), 64'd0);
    chk("rst_ready", 64'(fu_wb_ready), 64'd0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

    // Round-robin over four requesters, one writeback per cycle.
    nRST = 1'b1;
    wb_ready = 1'b1;
    #1 chk("rr_ready0", 64'(fu_wb_ready), 64'b0001);
    push_exp(5'd1, 32'hA0, 2'd0);
    tick();
    fu_wb_valid[0] = 1'b0;
    #1 chk("rr_ready1", 64'(fu_wb_ready), 64'b0010);
    chk("rr_out0", 64'(wb_data), 64'hA0);
    push_exp(5'd2, 32'hA1, 2'd1);
    tick();
    fu_wb_valid[1] = 1'b0;
    #1 chk("rr_ready2", 64'(fu_wb_ready), 64'b0100);
    push_exp(5'd3, 32'hA2, 2'd2);
    tick();
    fu_wb_valid[2] = 1'b0;
    #1 chk("rr_ready3", 64'(fu_wb_ready), 64'b1000);
    push_exp(5'd4, 32'hA3, 2'd3);
    tick();
    fu_wb_valid[3] = 1'b0;
    chk("rr_ptr_wrap", 64'(dut.rr_ptr_q), 64'd0);
    tick();
    chk("rr_drained", 64'(wb_valid), 64'd0);

    // Stall: held slot must stay put and no FU may be acked.
    set_fu(1, 1'b1, 5'd5, 32'h55, 1'b0);
    #1 chk("st_grant1", 64'(fu_wb_ready), 64'b0010);
    push_exp(5'd5, 32'h55, 2'd1);
    tick();
    set_fu(1, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fu(2, 1'b1, 5'd6, 32'h66, 1'b0);
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("st_ready", 64'(fu_wb_ready), 64'd0);
      chk("st_data", 64'(wb_data), 64'h55);
      tick();
    end
    chk("st_data_end", 64'(wb_data), 64'h55);
    wb_ready = 1'b1;
    #1 chk("st_grant2", 64'(fu_wb_ready), 64'b0100);
    push_exp(5'd6, 32'h66, 2'd2);
    tick();
    set_fu(2, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 chk("st_data_next", 64'(wb_data), 64'h66);
    tick();

    // Starvation: FU3 waits MAX_WAIT cycles and jumps ahead of rr_ptr=1.
    set_fu(0, 1'b1, 5'd14, 32'h30, 1'b0);
    #1 chk("sv_wrap_grant", 64'(fu_wb_ready), 64'b0001);
    push_exp(5'd14, 32'h30, 2'd0);
    tick();
    set_fu(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fu(3, 1'b1, 5'd15, 32'h33, 1'b0);
    wb_ready = 1'b0;
    #1 chk("sv_stall1", 64'(fu_wb_ready), 64'd0);
    tick();
    set_fu(0, 1'b1, 5'd16, 32'h40, 1'b0);
    set_fu(1, 1'b1, 5'd17, 32'h41, 1'b0);
    #1 chk("sv_stall2", 64'(fu_wb_ready), 64'd0);
    tick();
    wb_ready = 1'b1;
    #1 chk("sv_starved3", 64'(fu_wb_ready), 64'b1000);
    push_exp(5'd15, 32'h33, 2'd3);
    tick();
    set_fu(3, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 chk("sv_starved0", 64'(fu_wb_ready), 64'b0001);
    push_exp(5'd16, 32'h40, 2'd0);
    tick();
    set_fu(0, 1'b1, 5'd18, 32'h42, 1'b0);
    #1 chk("sv_starved1", 64'(fu_wb_ready), 64'b0010);
    push_exp(5'd17, 32'h41, 2'd1);
    tick();
    set_fu(1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 chk("sv_rr_after", 64'(fu_wb_ready), 64'b0001);
    push_exp(5'd18, 32'h42, 2'd0);
    tick();
    set_fu(0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();

    // Mispredict squashes a speculative held entry and speculative requesters.
    set_fu(1, 1'b1, 5'd7, 32'h77, 1'b1);
    #1 chk("bm_spec_grant", 64'(fu_wb_ready), 64'b0010);
    tick();
    set_fu(1, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fu(2, 1'b1, 5'd8, 32'h88, 1'b1);
    set_fu(0, 1'b1, 5'd9, 32'h99, 1'b0);
    wb_ready = 1'b0;
    branch_miss = 1'b1;
    #1 chk("bm_held_reg", 64'(wb_reg), 64'd7);
    chk("bm_ready", 64'(fu_wb_ready), 64'b0100);
    tick();
    branch_miss = 1'b0;
    set_fu(2, 1'b0, 5'd0, 32'h0, 1'b0);
    wb_ready = 1'b1;
    #1 chk("bm_squashed", 64'(wb_valid), 64'd0);
    chk("bm_next_grant", 64'(fu_wb_ready), 64'b0001);
    push_exp(5'd9, 32'h99, 2'd0);
    tick();
    set_fu(0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 chk("bm_out_reg", 64'(wb_reg), 64'd9);

    // Resolved entry survives a later mispredict while stalled.
    set_fu(3, 1'b1, 5'd10, 32'hAA, 1'b1);
    #1 chk("br_grant", 64'(fu_wb_ready), 64'b1000);
    push_exp(5'd10, 32'hAA, 2'd3);
    tick();
    set_fu(3, 1'b0, 5'd0, 32'h0, 1'b0);
    wb_ready = 1'b0;
    branch_resolved = 1'b1;
    tick();
    branch_resolved = 1'b0;
    branch_miss = 1'b1;
    set_fu(1, 1'b1, 5'd11, 32'hBB, 1'b0);
    #1 chk("br_nonspec_ready", 64'(fu_wb_ready), 64'd0);
    tick();
    branch_miss = 1'b0;
    #1 chk("br_survive_valid", 64'(wb_valid), 64'd1);
    chk("br_survive_data", 64'(wb_data), 64'hAA);
    wb_ready = 1'b1;
    #1 chk("br_next_grant", 64'(fu_wb_ready), 64'b0010);
    push_exp(5'd11, 32'hBB, 2'd1);
    tick();
    set_fu(1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 chk("br_out_data", 64'(wb_data), 64'hBB);

    // Asynchronous reset mid-stream drops the held entry and the handshake.
    set_fu(2, 1'b1, 5'd12, 32'hCC, 1'b0);
    #1 chk("ar_grant", 64'(fu_wb_ready), 64'b0100);
    tick();
    set_fu(2, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fu(1, 1'b1, 5'd13, 32'hDD, 1'b0);
    set_fu(3, 1'b1, 5'd19, 32'hEE, 1'b0);
    wb_ready = 1'b0;
    #1 chk("ar_pre_valid", 64'(wb_valid), 64'd1);
    #1 nRST = 1'b0;
    #1 chk("ar_valid", 64'(wb_valid), 64'd0);
    chk("ar_ready", 64'(fu_wb_ready), 64'd0);
    chk("ar_data", 64'(wb_data), 64'd0);
    chk("ar_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    tick();
    nRST = 1'b1;
    wb_ready = 1'b1;
    #1 chk("ar_first_grant", 64'(fu_wb_ready), 64'b0010);
    push_exp(5'd13, 32'hDD, 2'd1);
    tick();
    fu_wb_valid = '0;
    #1 chk("ar_out_valid", 64'(wb_valid), 64'd1);
    tick();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Arbitrates the single scoreboard writeback port among the functional units: scalar ALU, scalar memory, matrix load/store and GEMM.
- Each FU presents a writeback request through a valid/ready handshake.
- The block grants one request per cycle, round-robin, with starvation promotion. The winner goes into a registered output slot that feeds the scoreboard wb/wb_ctrl inputs.
- Speculative results are squashed on branch_miss, both in the queued requests and in the held output slot.

Parameters:
- NUM_FU, 4, number of requesting functional units.
- DATA_W, 32, writeback data width.
- REG_W, 5, destination register index width.
- MAX_WAIT, 8, wait cycles after which a pending requester is promoted to starved priority.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- fu_wb_valid  input  NUM_FU  per-FU writeback request.
- fu_wb_reg  input  NUM_FU*REG_W  per-FU destination register; FU i occupies slice [i*REG_W +: REG_W].
- fu_wb_data  input  NUM_FU*DATA_W  per-FU result data; FU i occupies slice [i*DATA_W +: DATA_W].
- fu_wb_spec  input  NUM_FU  per-FU flag: result was produced under an unresolved branch.
- fu_wb_ready  output  NUM_FU  per-FU acknowledge; combinational, at most one bit high except in a branch_miss cycle.
- branch_miss  input  1  mispredict; squash all speculative results.
- branch_resolved  input  1  branch resolved correctly; held result becomes non-speculative.
- wb_ready  input  1  consumer accepts wb_* this cycle.
- wb_valid  output  1  registered writeback valid.
- wb_reg  output  REG_W  registered destination register.
- wb_data  output  DATA_W  registered data.
- wb_fu  output  $clog2(NUM_FU)  index of the FU that produced the held result.

Behaviour:
- Reset values (nRST low, asynchronous): wb_valid=0, wb_reg=0, wb_data=0, wb_fu=0, internal out_spec=0, rr_ptr=0, all wait_cnt=0. fu_wb_ready is 0 while reset is asserted.
- Output slot load condition: load = !wb_valid || wb_ready.
- Latency: a request granted in cycle N appears on wb_* in cycle N+1.
- Handshake: a transfer from FU i occurs when fu_wb_valid[i] && fu_wb_ready[i]. The FU holds valid, reg, data and spec stable until that transfer.
- Grant selection, only when load=1 and branch_miss=0:
  - If any valid requester has wait_cnt == MAX_WAIT, the lowest-index such requester wins.
  - Otherwise the first valid requester searching from rr_ptr upward, wrapping at NUM_FU, wins.
- On a grant to FU g:
  - fu_wb_ready[g]=1.
  - The slot loads {reg, data, spec, fu=g} with wb_valid=1.
  - rr_ptr <= (g+1) mod NUM_FU.
- On load=1 with no valid requester: wb_valid <= 0 and rr_ptr is unchanged.
- Stall (wb_valid && !wb_ready):
  - wb_* are held bit-stable.
  - No grants are issued and all fu_wb_ready are 0.
- wait_cnt[i] update, per cycle:
  - Cleared when FU i transfers or fu_wb_valid[i]=0.
  - Otherwise increments, saturating at MAX_WAIT.
  - MAX_WAIT is representable in $clog2(MAX_WAIT+1) bits.
- branch_miss=1 (takes priority over everything else):
  - Every requester with fu_wb_valid[i] && fu_wb_spec[i] gets fu_wb_ready[i]=1. Those results are dropped and their wait_cnt cleared.
  - Non-speculative requesters get no grant and keep counting.
  - If the slot holds out_spec=1, wb_valid <= 0 regardless of wb_ready.
  - A non-speculative held entry follows the normal wb_ready rule.
  - rr_ptr is unchanged.
- branch_resolved=1 with branch_miss=0: out_spec <= 0 for the held entry. Requester spec bits are owned by the FUs.
- branch_miss and branch_resolved in the same cycle: branch_miss behaviour applies and branch_resolved is ignored.
- Single FU valid: it wins whenever load=1. Back-to-back requests from that FU therefore sustain 1 writeback per cycle while wb_ready=1.
- Reset asserted mid-transfer: the output slot and all counters clear immediately, and the pending handshake is not completed.

Test Plan:
- Reset, then FU0..3 all valid with data 0xA0..0xA3 and wb_ready=1 -> outputs 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles starting one cycle after the first grant; rr_ptr returns to 0.
- Slot holds FU1 data 0x55, wb_ready=0 for 3 cycles with FU2 valid -> wb_data stays 0x55, fu_wb_ready=0; FU2 is granted the cycle wb_ready returns, and wb_data=FU2 data the cycle after.
- FU0 and FU1 request continuously, FU3 held valid, MAX_WAIT=2 -> once wait_cnt[3] reaches 2, FU3 is granted next regardless of rr_ptr.
- Slot holds spec entry reg 7; FU2 valid spec=1; FU0 valid spec=0; assert branch_miss -> wb_valid=0 the next cycle; fu_wb_ready=4'b0100; FU0 is granted the following cycle.
- Slot holds spec entry; branch_resolved pulses, then branch_miss next cycle with wb_ready=0 -> entry survives and is written when wb_ready=1.
- Assert nRST low mid-stream with wb_valid=1 -> wb_valid=0 and fu_wb_ready=0 immediately (asynchronous); after release the first grant goes to the lowest valid FU from rr_ptr=0.
